// File: rtl/flat_shade_if.sv
// Triangle-in / shade-out handshake bundle for flat_shade_pipe.
// Vectors are packed [2:0][31:0] with index 0 = x, 1 = y, 2 = z.
interface flat_shade_if #(
  parameter int unsigned COLOR_W = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0][31:0]      p1;
  logic [2:0][31:0]      p2;
  logic [2:0][31:0]      p3;
  logic [2:0][31:0]      light_dir;
  logic                  out_valid;
  logic                  out_ready;
  logic [COLOR_W-1:0]    color;
  logic                  culled;
  logic                  degenerate;
  logic                  busy;

  modport master (
    output in_valid, p1, p2, p3, light_dir, out_ready,
    input  in_ready, out_valid, color, culled, degenerate, busy
  );

  modport slave (
    input  in_valid, p1, p2, p3, light_dir, out_ready,
    output in_ready, out_valid, color, culled, degenerate, busy
  );
endinterface

// File: rtl/flat_shade_pipe.sv
// Flat-shading sequencer: face normal, n.l / |n| against a light direction, quantised to a
// COLOR_W-bit shade with ambient floor, saturation, back-face cull and degenerate detection.
module flat_shade_pipe #(
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned AMBIENT  = 1,
  parameter bit          CULL_EN  = 1'b1,
  parameter int unsigned ADD_LAT  = 7,
  parameter int unsigned MUL_LAT  = 5,
  parameter int unsigned SQRT_LAT = 6,
  parameter int unsigned DIV_LAT  = 11,
  parameter int unsigned DOT_LAT  = 8,
  parameter int unsigned CVT_LAT  = 3
) (
  input  logic        clk,
  input  logic        areset,
  flat_shade_if.slave bus
);
  // Q7.12 signed coordinates; |x| >= 128 is treated like Inf/NaN.
  localparam int unsigned F    = 12;
  localparam int unsigned CW   = 20;
  localparam int unsigned NW   = 2 * CW + 2;
  localparam int unsigned NNW  = 2 * NW;
  localparam int unsigned LW   = NW + CW + 1;
  localparam int unsigned SW   = LW + COLOR_W;
  localparam int unsigned CntW = 16;

  localparam int unsigned DurSub   = 6 + ADD_LAT;
  localparam int unsigned DurCross = 6 + MUL_LAT + 3 + ADD_LAT;
  localparam int unsigned DurDots  = 2 + DOT_LAT;
  localparam int unsigned DurSqrt  = 1 + SQRT_LAT;
  localparam int unsigned DurDiv   = 1 + DIV_LAT;
  localparam int unsigned DurScale = 1 + MUL_LAT;
  localparam int unsigned DurCvt   = 1 + CVT_LAT;

  typedef enum logic [3:0] {
    StIdle, StSub, StCross, StDots, StSqrt, StDiv, StScale, StCvt, StOut
  } state_e;

  // Returns {bad, value}; bad flags NaN/Inf and out-of-range magnitudes.
  function automatic logic [CW:0] to_fx(input logic [31:0] f);
    logic [23:0]   sh;
    logic [CW-1:0] m;
    if (f[30:23] >= 8'd134) return {1'b1, {CW{1'b0}}};
    if (f[30:23] < 8'd115) return '0;
    sh = {1'b1, f[22:0]} >> (8'd138 - f[30:23]);
    m  = sh[CW-1:0];
    return {1'b0, f[31] ? -m : m};
  endfunction

  function automatic logic [NW-1:0] isqrt(input logic [NNW-1:0] x);
    logic [NW-1:0] r;
    logic [NW-1:0] c;
    r = '0;
    for (int k = NW - 1; k >= 0; k--) begin
      c = r | (NW'(1) << k);
      if (NNW'(c) * NNW'(c) <= x) r = c;
    end
    return r;
  endfunction

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic signed [CW-1:0]     v_q [4][3];
  logic                     bad_q;
  logic signed [NW-1:0]     a_q [3];
  logic signed [NW-1:0]     b_q [3];
  logic signed [NW-1:0]     n_q [3];
  logic [NNW-1:0]           nn_q;
  logic signed [LW-1:0]     nl_q;
  logic [NW-1:0]            mag_q;
  logic [LW-1:0]            i_q;
  logic [SW-1:0]            sc_q;
  logic [COLOR_W-1:0]       color_q;
  logic                     culled_q, degen_q;

  logic [CW:0]              cv [4][3];
  logic                     bad_in, accept, last, degen_now, cull_now;
  logic signed [NW-1:0]     a_c [3];
  logic signed [NW-1:0]     b_c [3];
  logic signed [NW-1:0]     n_c [3];
  logic [NNW-1:0]           nn_c;
  logic signed [LW-1:0]     nl_c;
  logic [NW-1:0]            mag_c;
  logic [LW-1:0]            nl_abs, quo_c;
  logic [SW-1:0]            q_c;
  logic [COLOR_W-1:0]       sat_c;

  assign accept = (state_q == StIdle) && bus.in_valid;

  always_comb begin
    bad_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cv[0][c] = to_fx(bus.p1[c]);
      cv[1][c] = to_fx(bus.p2[c]);
      cv[2][c] = to_fx(bus.p3[c]);
      cv[3][c] = to_fx(bus.light_dir[c]);
      for (int k = 0; k < 4; k++) bad_in = bad_in | cv[k][c][CW];
      a_c[c] = NW'(v_q[1][c]) - NW'(v_q[0][c]);
      b_c[c] = NW'(v_q[2][c]) - NW'(v_q[0][c]);
    end
    n_c[0] = a_q[1] * b_q[2] - a_q[2] * b_q[1];
    n_c[1] = a_q[2] * b_q[0] - a_q[0] * b_q[2];
    n_c[2] = a_q[0] * b_q[1] - a_q[1] * b_q[0];
    nn_c   = NNW'(n_q[0]) * NNW'(n_q[0]) + NNW'(n_q[1]) * NNW'(n_q[1])
           + NNW'(n_q[2]) * NNW'(n_q[2]);
    nl_c   = LW'(n_q[0]) * LW'(v_q[3][0]) + LW'(n_q[1]) * LW'(v_q[3][1])
           + LW'(n_q[2]) * LW'(v_q[3][2]);
    mag_c  = isqrt(nn_q);
    nl_abs = nl_q[LW-1] ? -nl_q : nl_q;
    quo_c  = nl_abs / LW'(mag_q);
    q_c    = sc_q >> F;
    // Negative intensity truncates to a value below any ambient floor.
    if (nl_q[LW-1] || q_c < SW'(AMBIENT)) sat_c = COLOR_W'(AMBIENT);
    else if (q_c >= (SW'(1) << COLOR_W))  sat_c = '1;
    else                                  sat_c = q_c[COLOR_W-1:0];
    degen_now = bad_q || (nn_c == '0);
    cull_now  = CULL_EN && (nl_c[LW-1] || (nl_c == '0));
  end

  always_comb begin
    case (state_q)
      StSub:   last = (cnt_q == CntW'(DurSub - 1));
      StCross: last = (cnt_q == CntW'(DurCross - 1));
      StDots:  last = (cnt_q == CntW'(DurDots - 1));
      StSqrt:  last = (cnt_q == CntW'(DurSqrt - 1));
      StDiv:   last = (cnt_q == CntW'(DurDiv - 1));
      StScale: last = (cnt_q == CntW'(DurScale - 1));
      StCvt:   last = (cnt_q == CntW'(DurCvt - 1));
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      StIdle:  if (bus.in_valid) state_d = StSub;
      StSub:   if (last) state_d = StCross;
      StCross: if (last) state_d = StDots;
      StDots:  if (last) state_d = (degen_now || cull_now) ? StOut : StSqrt;
      StSqrt:  if (last) state_d = StDiv;
      StDiv:   if (last) state_d = StScale;
      StScale: if (last) state_d = StCvt;
      StCvt:   if (last) state_d = StOut;
      StOut:   if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (last || state_q == StIdle || state_q == StOut) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      v_q      <= '{default: '0};
      bad_q    <= 1'b0;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      n_q      <= '{default: '0};
      nn_q     <= '0;
      nl_q     <= '0;
      mag_q    <= '0;
      i_q      <= '0;
      sc_q     <= '0;
      color_q  <= '0;
      culled_q <= 1'b0;
      degen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        for (int k = 0; k < 4; k++)
          for (int c = 0; c < 3; c++) v_q[k][c] <= cv[k][c][CW-1:0];
        bad_q    <= bad_in;
        culled_q <= 1'b0;
        degen_q  <= 1'b0;
      end
      if (last) begin
        case (state_q)
          StSub: begin
            a_q <= a_c;
            b_q <= b_c;
          end
          StCross: n_q <= n_c;
          StDots: begin
            nn_q <= nn_c;
            nl_q <= nl_c;
            if (degen_now) begin
              degen_q <= 1'b1;
              color_q <= COLOR_W'(AMBIENT);
            end else if (cull_now) begin
              culled_q <= 1'b1;
              color_q  <= COLOR_W'(AMBIENT);
            end
          end
          StSqrt:  mag_q   <= mag_c;
          StDiv:   i_q     <= quo_c;
          StScale: sc_q    <= {i_q, {COLOR_W{1'b0}}};
          StCvt:   color_q <= sat_c;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.out_valid  = (state_q == StOut);
  assign bus.color      = color_q;
  assign bus.culled     = culled_q;
  assign bus.degenerate = degen_q;
endmodule

// File: tb/tb_flat_shade_pipe.sv
// Directed bench: a culling and a non-culling instance share one stimulus bus.
`timescale 1ns/1ps
module tb_flat_shade_pipe;
  localparam logic [31:0] F0   = 32'h0000_0000;
  localparam logic [31:0] F1   = 32'h3f80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] FM1  = 32'hbf80_0000;
  localparam logic [31:0] F06  = 32'h3f19_999a;
  localparam logic [31:0] F08  = 32'h3f4c_cccd;
  localparam logic [31:0] F005 = 32'h3d4c_cccd;
  localparam logic [31:0] FNAN = 32'h7fc0_0000;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  flat_shade_if #(.COLOR_W(4)) bus ();
  flat_shade_if #(.COLOR_W(4)) bus_nc ();

  assign bus_nc.in_valid  = bus.in_valid;
  assign bus_nc.p1        = bus.p1;
  assign bus_nc.p2        = bus.p2;
  assign bus_nc.p3        = bus.p3;
  assign bus_nc.light_dir = bus.light_dir;
  assign bus_nc.out_ready = bus.out_ready;

  flat_shade_pipe #(.COLOR_W(4), .AMBIENT(1), .CULL_EN(1'b1)) dut (
    .clk(clk), .areset(areset), .bus(bus)
  );
  flat_shade_pipe #(.COLOR_W(4), .AMBIENT(1), .CULL_EN(1'b0)) dut_nc (
    .clk(clk), .areset(areset), .bus(bus_nc)
  );

  int errors = 0;
  int checks = 0;
  int lat_full = 0;
  int lat_early = 0;
  int r_lat, n_lat;
  logic [3:0] r_col, n_col;
  logic r_cul, r_deg, n_cul, n_deg;

  function automatic logic [2:0][31:0] vec(input logic [31:0] x, y, z);
    return {z, y, x};
  endfunction

  task automatic start_job(input logic [2:0][31:0] v1, v2, v3, l);
    @(negedge clk);
    bus.p1 = v1; bus.p2 = v2; bus.p3 = v3; bus.light_dir = l;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.p1 = '1; bus.p2 = '1; bus.p3 = '1; bus.light_dir = '1;
  endtask

  // Latency k = negedges after the accepting posedge until out_valid is seen.
  task automatic run_job(input logic [2:0][31:0] v1, v2, v3, l);
    bit got, got_nc;
    got = 1'b0; got_nc = 1'b0;
    start_job(v1, v2, v3, l);
    for (int k = 1; k <= 400 && !(got && got_nc); k++) begin
      if (!got && bus.out_valid) begin
        got = 1'b1; r_lat = k; r_col = bus.color; r_cul = bus.culled; r_deg = bus.degenerate;
      end
      if (!got_nc && bus_nc.out_valid) begin
        got_nc = 1'b1; n_lat = k; n_col = bus_nc.color;
        n_cul = bus_nc.culled; n_deg = bus_nc.degenerate;
      end
      if (!(got && got_nc)) @(negedge clk);
    end
    checks++;
    if (!(got && got_nc)) begin
      errors++;
      $display("FAIL job_timeout: got=%0b got_nc=%0b required 1 1", got, got_nc);
    end
    if (bus.out_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.p1 = '0; bus.p2 = '0; bus.p3 = '0; bus.light_dir = '0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus_nc.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %0b/%0b required 1", bus.in_ready, bus_nc.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_valid_busy: got %0b %0b required 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.color !== 4'd0 || bus.culled !== 1'b0 || bus.degenerate !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got c=%0d cu=%0b dg=%0b required 0 0 0",
               bus.color, bus.culled, bus.degenerate);
    end
  endtask

  task automatic test_lit_saturate();
    run_job(vec(F0, F0, F0), vec(F1, F0, F0), vec(F0, F1, F0), vec(F0, F0, F1));
    lat_full = r_lat;
    checks++;
    if (r_col !== 4'd15 || r_cul !== 1'b0 || r_deg !== 1'b0) begin
      errors++; $display("FAIL lit_saturate: got c=%0d cu=%0b dg=%0b required 15 0 0", r_col, r_cul, r_deg);
    end
    checks++;
    if (n_col !== 4'd15 || n_lat !== lat_full) begin
      errors++; $display("FAIL lit_saturate_nc: got c=%0d lat=%0d required 15 %0d", n_col, n_lat, lat_full);
    end
  endtask

  task automatic test_normalise();
    run_job(vec(F0, F0, F0), vec(F2, F0, F0), vec(F0, F2, F0), vec(F0, F06, F08));
    checks++;
    if (r_col !== 4'd12 || r_cul !== 1'b0 || r_deg !== 1'b0) begin
      errors++; $display("FAIL normalise: got c=%0d cu=%0b dg=%0b required 12 0 0", r_col, r_cul, r_deg);
    end
    checks++;
    if (r_lat !== lat_full || n_lat !== lat_full) begin
      errors++; $display("FAIL normalise_latency: got %0d/%0d required %0d", r_lat, n_lat, lat_full);
    end
    checks++;
    if (n_col !== 4'd12) begin
      errors++; $display("FAIL normalise_nc: got %0d required 12", n_col);
    end
  endtask

  task automatic test_dim_ambient();
    run_job(vec(F0, F0, F0), vec(F1, F0, F0), vec(F0, F1, F0), vec(F0, F0, F005));
    checks++;
    if (r_col !== 4'd1 || r_cul !== 1'b0 || r_deg !== 1'b0 || r_lat !== lat_full) begin
      errors++;
      $display("FAIL dim_ambient: got c=%0d cu=%0b dg=%0b lat=%0d required 1 0 0 %0d",
               r_col, r_cul, r_deg, r_lat, lat_full);
    end
  endtask

  task automatic test_backface();
    run_job(vec(F0, F0, F0), vec(F1, F0, F0), vec(F0, F1, F0), vec(F0, F0, FM1));
    lat_early = r_lat;
    checks++;
    if (r_col !== 4'd1 || r_cul !== 1'b1 || r_deg !== 1'b0) begin
      errors++; $display("FAIL backface_cull: got c=%0d cu=%0b dg=%0b required 1 1 0", r_col, r_cul, r_deg);
    end
    checks++;
    if (!(lat_early < lat_full)) begin
      errors++; $display("FAIL backface_early_exit: got lat %0d required below %0d", lat_early, lat_full);
    end
    checks++;
    if (n_col !== 4'd1 || n_cul !== 1'b0 || n_deg !== 1'b0 || n_lat !== lat_full) begin
      errors++;
      $display("FAIL backface_nocull: got c=%0d cu=%0b dg=%0b lat=%0d required 1 0 0 %0d",
               n_col, n_cul, n_deg, n_lat, lat_full);
    end
  endtask

  task automatic test_degenerate();
    run_job(vec(F0, F0, F0), vec(F1, F1, F1), vec(F2, F2, F2), vec(F0, F0, F1));
    checks++;
    if (r_col !== 4'd1 || r_cul !== 1'b0 || r_deg !== 1'b1 || r_lat !== lat_early) begin
      errors++;
      $display("FAIL degenerate: got c=%0d cu=%0b dg=%0b lat=%0d required 1 0 1 %0d",
               r_col, r_cul, r_deg, r_lat, lat_early);
    end
    checks++;
    if (n_col !== 4'd1 || n_deg !== 1'b1 || n_lat !== lat_early) begin
      errors++;
      $display("FAIL degenerate_nc: got c=%0d dg=%0b lat=%0d required 1 1 %0d", n_col, n_deg, n_lat, lat_early);
    end
  endtask

  task automatic test_nan();
    run_job(vec(FNAN, F0, F0), vec(F1, F0, F0), vec(F0, F1, F0), vec(F0, F0, F1));
    checks++;
    if (r_col !== 4'd1 || r_deg !== 1'b1 || r_cul !== 1'b0 || r_lat !== lat_early) begin
      errors++;
      $display("FAIL nan_input: got c=%0d cu=%0b dg=%0b lat=%0d required 1 0 1 %0d",
               r_col, r_cul, r_deg, r_lat, lat_early);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    run_job(vec(F0, F0, F0), vec(F2, F0, F0), vec(F0, F2, F0), vec(F0, F06, F08));
    checks++;
    if (r_col !== 4'd12) begin
      errors++; $display("FAIL hold_result: got %0d required 12", r_col);
    end
    // Offer a different job while stalled; it must not be taken.
    bus.p1 = vec(F0, F0, F0); bus.p2 = vec(F1, F0, F0);
    bus.p3 = vec(F0, F1, F0); bus.light_dir = vec(F0, F0, F1);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.color !== 4'd12 ||
          bus.culled !== 1'b0 || bus.degenerate !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got v=%0b r=%0b c=%0d cu=%0b dg=%0b required 1 0 12 0 0",
                 k, bus.out_valid, bus.in_ready, bus.color, bus.culled, bus.degenerate);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL release: got v=%0b r=%0b b=%0b required 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_abort();
    start_job(vec(F0, F0, F0), vec(F1, F0, F0), vec(F0, F1, F0), vec(F0, F0, F1));
    repeat (19) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got %0b required 1", bus.busy);
    end
    areset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reset: got b=%0b v=%0b r=%0b required 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    areset = 1'b0;
    run_job(vec(F0, F0, F0), vec(F2, F0, F0), vec(F0, F2, F0), vec(F0, F06, F08));
    checks++;
    if (r_col !== 4'd12 || r_lat !== lat_full) begin
      errors++; $display("FAIL abort_next_job: got c=%0d lat=%0d required 12 %0d", r_col, r_lat, lat_full);
    end
  endtask

  initial begin
    test_reset();
    test_lit_saturate();
    test_normalise();
    test_dim_ambient();
    test_backface();
    test_degenerate();
    test_nan();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
